// File: rtl/scc_mem_arbiter.sv
// Arbitrates the single unified memory port between the scc fetch unit and its load/store unit.
// One transaction in flight; data wins unless a pending fetch has waited through MAX_DATA_STREAK data grants.
module scc_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_misalign
);

  localparam int SW    = $clog2(MAX_DATA_STREAK + 1);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q;
  logic [SW-1:0]       streak_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                own_data_q;
  logic                we_q;
  logic                mis_q;
  logic                if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q;
  logic                mem_read_q, mem_write_q, busy_q, err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, d_rdata_q;

  logic                fetch_ok_s;
  logic                pick_fetch_s;
  logic                pick_data_s;
  logic                d_mis_s;

  // Arbitration: a starved fetch first, then data, then an ordinary fetch.
  always_comb begin
    fetch_ok_s   = if_req && !halt;
    d_mis_s      = (d_addr[1:0] != 2'b00);
    pick_fetch_s = 1'b0;
    pick_data_s  = 1'b0;
    if (fetch_ok_s && (streak_q == STREAK_MAX)) begin
      pick_fetch_s = 1'b1;
    end else if (d_req) begin
      pick_data_s = 1'b1;
    end else if (fetch_ok_s) begin
      pick_fetch_s = 1'b1;
    end else begin
      pick_fetch_s = 1'b0;
      pick_data_s  = 1'b0;
    end
  end

  // Transaction FSM; every output is registered and pulses default low each enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      cnt_q       <= '0;
      own_data_q  <= 1'b0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else if (clk_en) begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_fetch_s) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            if_gnt_q   <= 1'b1;
            mem_read_q <= 1'b1;
            mem_addr_q <= if_addr;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            streak_q   <= '0;
          end else if (pick_data_s) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            d_gnt_q     <= 1'b1;
            own_data_q  <= 1'b1;
            we_q        <= d_we;
            mis_q       <= d_mis_s;
            mem_addr_q  <= d_addr;
            mem_read_q  <= !d_we && !d_mis_s;
            mem_write_q <= d_we && !d_mis_s;
            mem_wdata_q <= d_we ? d_wdata : '0;
            if (d_mis_s) begin
              err_q <= 1'b1;
            end
            if (streak_q != STREAK_MAX) begin
              streak_q <= streak_q + SW'(1);
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ISSUE: begin
          if (we_q || mis_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            // A misaligned load never touches memory but still owes the requester a response.
            if (mis_q && !we_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= '0;
            end
          end else begin
            state_q <= WAIT;
            cnt_q   <= LAT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
            if (own_data_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_rdata;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt       = if_gnt_q;
  assign if_rvalid    = if_rvalid_q;
  assign if_rdata     = if_rdata_q;
  assign d_gnt        = d_gnt_q;
  assign d_rvalid     = d_rvalid_q;
  assign d_rdata      = d_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign err_misalign = err_q;

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Bench for scc_mem_arbiter: directed scenarios plus a randomized run against a transaction-schedule model.
module tb_scc_mem_arbiter;

  localparam int MEM_LAT = 1;
  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst, clk_en, halt;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy, err_misalign;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_pass = 0;
  int n_checks = 0;

  scc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .MAX_DATA_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  // 16-word synchronous memory, one cycle read latency, with a bench-side preload port.
  logic [31:0] mem [16];
  logic [31:0] rd_q;
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (clk_en && mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    if (clk_en && mem_read) rd_q <= mem[mem_addr[5:2]];
  end
  assign mem_rdata = rd_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1;
    pl_idx = idx[3:0];
    pl_data = v;
    step();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; halt = 1'b0; clk_en = 1'b1; d_we = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    n_checks++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy, err_misalign} !== 8'h00 ||
        {if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'd0)
      $display("FAIL reset_outputs got ctrl=%b addr=%h", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy, err_misalign}, mem_addr);
    else n_pass++;
    rst = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
    step();
    d_req = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_in_wait_busy got=%b exp=1", busy);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy, err_misalign} !== 8'h00)
      $display("FAIL reset_mid_wait got=%b exp=00000000", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write, busy, err_misalign});
    else n_pass++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (d_rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_no_rvalid cyc=%0d rvalid=%b busy=%b exp=0/0", i, d_rvalid, busy);
      else n_pass++;
    end
  endtask

  task automatic test_single_fetch();
    preload(4, 32'hDEAD_BEEF);
    if_req = 1'b1; if_addr = 32'h0000_0010;
    step();
    n_checks++;
    if ({if_gnt, mem_read, mem_write, d_gnt, busy} !== 5'b11001 || mem_addr !== 32'h0000_0010)
      $display("FAIL fetch_issue got=%b addr=%h exp=11001 addr=00000010", {if_gnt, mem_read, mem_write, d_gnt, busy}, mem_addr);
    else n_pass++;
    if_req = 1'b0;
    step();
    n_checks++;
    if ({if_rvalid, if_gnt, mem_read} !== 3'b000) $display("FAIL fetch_wait got=%b exp=000", {if_rvalid, if_gnt, mem_read});
    else n_pass++;
    step();
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_resp got=%b/%h exp=1/deadbeef", if_rvalid, if_rdata);
    else n_pass++;
    step();
    n_checks++;
    if ({if_rvalid, busy} !== 2'b00 || if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_hold got=%b/%h exp=00/deadbeef", {if_rvalid, busy}, if_rdata);
    else n_pass++;
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'h0000_0055;
    step();
    n_checks++;
    if ({d_gnt, mem_write, mem_read, d_rvalid, busy} !== 5'b11001) $display("FAIL store_issue got=%b exp=11001", {d_gnt, mem_write, mem_read, d_rvalid, busy});
    else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0000_0020 || mem_wdata !== 32'h0000_0055) $display("FAIL store_bus got=%h/%h exp=00000020/00000055", mem_addr, mem_wdata);
    else n_pass++;
    d_req = 1'b0;
    step();
    n_checks++;
    if ({busy, mem_write, d_rvalid} !== 3'b000) $display("FAIL store_done got=%b exp=000", {busy, mem_write, d_rvalid});
    else n_pass++;
    step();
    n_checks++;
    if (d_rvalid !== 1'b0 || mem[8] !== 32'h0000_0055) $display("FAIL store_mem got=%b/%h exp=0/00000055", d_rvalid, mem[8]);
    else n_pass++;
  endtask

  task automatic test_starvation();
    int seq[$];
    bit both;
    do_reset();
    preload(1, 32'h1111_2222);
    both = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0004;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0008; d_wdata = $urandom;
    for (int c = 0; c < 300 && seq.size() < 15; c++) begin
      step();
      if (if_gnt && d_gnt) both = 1'b1;
      if (d_gnt) seq.push_back(1);
      else if (if_gnt) seq.push_back(0);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) step();
    n_checks++;
    if (both) $display("FAIL starve_both_gnt got=1 exp=0");
    else n_pass++;
    n_checks++;
    if (seq.size() != 15) $display("FAIL starve_count got=%0d exp=15", seq.size());
    else n_pass++;
    for (int i = 0; i < 15; i++) begin
      if (i < seq.size()) begin
        n_checks++;
        if (seq[i] != ((i % 5 == 4) ? 0 : 1)) $display("FAIL starve_order idx=%0d got=%0d exp=%0d", i, seq[i], (i % 5 == 4) ? 0 : 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_halt();
    int seen_if, seen_d;
    bit got;
    preload(1, 32'h0BAD_F00D);
    halt = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0004;
    seen_if = 0; seen_d = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_000C; d_wdata = 32'h0000_00AA;
      end
      step();
      if (if_gnt) seen_if++;
      if (d_gnt) begin seen_d++; d_req = 1'b0; end
    end
    n_checks++;
    if (seen_if != 0) $display("FAIL halt_blocks_fetch got=%0d exp=0", seen_if);
    else n_pass++;
    n_checks++;
    if (seen_d != 1) $display("FAIL halt_data_served got=%0d exp=1", seen_d);
    else n_pass++;
    halt = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (if_gnt) got = 1'b1;
    end
    n_checks++;
    if (!got) $display("FAIL halt_release_fetch got=0 exp=1");
    else n_pass++;
    halt = 1'b1; if_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (if_rvalid) got = 1'b1;
    end
    n_checks++;
    if (!got || if_rdata !== 32'h0BAD_F00D) $display("FAIL halt_inflight got=%b/%h exp=1/0badf00d", got, if_rdata);
    else n_pass++;
    halt = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_misaligned_clk_en();
    bit bad;
    preload(12, 32'h1234_5678);
    n_checks++;
    if (err_misalign !== 1'b0) $display("FAIL err_clear got=%b exp=0", err_misalign);
    else n_pass++;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0030;
    step();
    n_checks++;
    if (d_gnt !== 1'b1) $display("FAIL stall_gnt got=%b exp=1", d_gnt);
    else n_pass++;
    d_req = 1'b0;
    step();
    bad = (d_rvalid !== 1'b0);
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (d_rvalid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    clk_en = 1'b1;
    n_checks++;
    if (bad) $display("FAIL stall_early got=early_rvalid exp=held");
    else n_pass++;
    step();
    n_checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678) $display("FAIL stall_resp got=%b/%h exp=1/12345678", d_rvalid, d_rdata);
    else n_pass++;
    step();
    n_checks++;
    if (d_rvalid !== 1'b0) $display("FAIL stall_pulse got=%b exp=0", d_rvalid);
    else n_pass++;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0022;
    step();
    n_checks++;
    if ({d_gnt, mem_read, mem_write, err_misalign} !== 4'b1001) $display("FAIL mis_issue got=%b exp=1001", {d_gnt, mem_read, mem_write, err_misalign});
    else n_pass++;
    d_req = 1'b0;
    step();
    n_checks++;
    if ({d_rvalid, busy, mem_read, mem_write} !== 4'b1000 || d_rdata !== 32'd0) $display("FAIL mis_resp got=%b/%h exp=1000/00000000", {d_rvalid, busy, mem_read, mem_write}, d_rdata);
    else n_pass++;
    step();
    n_checks++;
    if (d_rvalid !== 1'b0 || err_misalign !== 1'b1) $display("FAIL mis_sticky got=%b/%b exp=0/1", d_rvalid, err_misalign);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] shadow [16];
    logic [31:0] v, g_addr, g_wd, rv_data, e_ifr, e_dr;
    logic [7:0]  exp_v, act_v;
    logic        g_rd, g_wr, fok, mis;
    int next_arb, g_cyc, g_own, rv_cyc, rv_own, busy_hi, err_from, streak, pick;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      shadow[i] = v;
      preload(i, v);
    end
    next_arb = 0; g_cyc = -1; g_own = 0; rv_cyc = -1; rv_own = 0; busy_hi = -1; err_from = -1; streak = 0;
    g_rd = 1'b0; g_wr = 1'b0; g_addr = 32'd0; g_wd = 32'd0; rv_data = 32'd0; e_ifr = 32'd0; e_dr = 32'd0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (rv_cyc == cyc) begin
        if (rv_own == 0) e_ifr = rv_data; else e_dr = rv_data;
      end
      exp_v = {g_cyc == cyc && g_own == 0, g_cyc == cyc && g_own == 1, g_cyc == cyc && g_rd, g_cyc == cyc && g_wr,
               rv_cyc == cyc && rv_own == 0, rv_cyc == cyc && rv_own == 1,
               g_cyc >= 0 && cyc >= g_cyc && cyc <= busy_hi, err_from >= 0 && cyc >= err_from};
      act_v = {if_gnt, d_gnt, mem_read, mem_write, if_rvalid, d_rvalid, busy, err_misalign};
      n_checks++;
      if (act_v !== exp_v) $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc, act_v, exp_v);
      else n_pass++;
      n_checks++;
      if (if_rdata !== e_ifr || d_rdata !== e_dr) $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, if_rdata, d_rdata, e_ifr, e_dr);
      else n_pass++;
      if (g_cyc == cyc && (g_rd || g_wr)) begin
        n_checks++;
        if (mem_addr !== g_addr || (g_wr && mem_wdata !== g_wd)) $display("FAIL rand_bus cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_addr, mem_wdata, g_addr, g_wd);
        else n_pass++;
      end
      if (g_cyc == cyc && g_own == 0) if_req = 1'b0;
      if (g_cyc == cyc && g_own == 1) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1;
        if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        if ($urandom_range(0, 7) == 0) d_addr[1:0] = 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      if (cyc >= next_arb) begin
        fok = if_req && !halt;
        pick = -1;
        if (fok && streak == MAX_STREAK) pick = 0;
        else if (d_req) pick = 1;
        else if (fok) pick = 0;
        if (pick == 0) begin
          g_cyc = cyc + 1; g_own = 0; g_rd = 1'b1; g_wr = 1'b0; g_addr = if_addr; streak = 0;
          rv_cyc = cyc + 2 + MEM_LAT; rv_own = 0; rv_data = shadow[if_addr[5:2]];
          next_arb = cyc + 3 + MEM_LAT;
        end else if (pick == 1) begin
          mis = (d_addr[1:0] != 2'b00);
          g_cyc = cyc + 1; g_own = 1; g_addr = d_addr; g_wd = d_wdata;
          g_rd = !d_we && !mis; g_wr = d_we && !mis;
          if (streak < MAX_STREAK) streak++;
          if (mis && err_from < 0) err_from = cyc + 1;
          if (g_rd) begin
            rv_cyc = cyc + 2 + MEM_LAT; rv_own = 1; rv_data = shadow[d_addr[5:2]];
            next_arb = cyc + 3 + MEM_LAT;
          end else if (mis && !d_we) begin
            rv_cyc = cyc + 2; rv_own = 1; rv_data = 32'd0;
            next_arb = cyc + 2;
          end else begin
            next_arb = cyc + 2;
          end
          if (g_wr) shadow[d_addr[5:2]] = d_wdata;
        end
        busy_hi = next_arb - 1;
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0; halt = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b1; halt = 1'b0; pl_en = 1'b0; pl_idx = 4'd0; pl_data = 32'd0;
    if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    #1;
    test_reset();
    test_single_fetch();
    test_store();
    test_starvation();
    test_halt();
    test_misaligned_clk_en();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
